// File: rtl/mem_arb_pkg.sv
// Shared types and codes for the two-port memory arbiter: FSM states, write-size codes, port ids.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR,
    RSP
  } state_e;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_BYTE = 2'b01;
  localparam logic [1:0] WR_HALF = 2'b10;
  localparam logic [1:0] WR_WORD = 2'b11;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner select between fetch (bit 0) and load/store (bit 1) requests.
// ARB_ROUND_ROBIN_EN selects round-robin on a tie; otherwise port 0 always wins.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       rr_ptr_i,
  output logic [1:0] grant_o
);

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie the pointer names the favoured port.
  always_comb begin
    if (req0_i && req1_i) begin
      grant_o = (rr_ptr_i == PORT_DATA) ? 2'b10 : 2'b01;
    end else begin
      grant_o = {req1_i, req0_i};
    end
  end
`else
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr_i;

  always_comb begin
    if (req0_i) begin
      grant_o = 2'b01;
    end else begin
      grant_o = {req1_i, 1'b0};
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressable memory between fetch (port 0) and load/store (port 1),
// sequencing read wait states and write completion. ARB_ROUND_ROBIN_EN enables round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WR_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [1:0]        wsize0_i,
  input  logic [1:0]        wsize1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rsp_valid0_o,
  output logic              rsp_valid1_o,
  output logic              rsp_err_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [1:0]        mem_write_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_done_i,
  input  logic              mem_error_i
);

  localparam int CNT_W = $clog2(WR_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              winner_q, winner_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [1:0]        mem_write_q, mem_write_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       rr_ptr;
  logic [1:0] grant;
  logic       sel_port;
  logic [1:0] sel_wsize;

  mem_arb_picker u_picker (
    .req0_i  (req0_i),
    .req1_i  (req1_i),
    .rr_ptr_i(rr_ptr),
    .grant_o (grant)
  );

  assign sel_port  = grant[1];
  assign sel_wsize = sel_port ? wsize1_i : wsize0_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= PORT_FETCH;
    end else if (state_q == IDLE && grant != 2'b00) begin
      rr_ptr_q <= ~sel_port;
    end
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = PORT_FETCH;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      winner_q      <= PORT_FETCH;
      err_q         <= 1'b0;
      mem_address_q <= '0;
      mem_write_q   <= WR_NONE;
      mem_wdata_q   <= '0;
      rsp_rdata_q   <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      err_q         <= err_d;
      mem_address_q <= mem_address_d;
      mem_write_q   <= mem_write_d;
      mem_wdata_q   <= mem_wdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      cnt_q         <= cnt_d;
    end
  end

  // NOTE: every next-state signal holds its value by default, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    err_d         = err_q;
    mem_address_d = mem_address_q;
    mem_write_d   = mem_write_q;
    mem_wdata_d   = mem_wdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          winner_d      = sel_port;
          err_d         = 1'b0;
          cnt_d         = '0;
          mem_address_d = sel_port ? addr1_i : addr0_i;
          mem_wdata_d   = sel_port ? wdata1_i : wdata0_i;
          mem_write_d   = sel_wsize;
          state_d       = (sel_wsize == WR_NONE) ? RD1 : WR;
        end
      end
      RD1: begin
        if (mem_error_i) begin
          err_d   = 1'b1;
          state_d = RSP;
        end else begin
          state_d = RD2;
        end
      end
      RD2: begin
        if (mem_error_i) begin
          err_d = 1'b1;
        end else begin
          rsp_rdata_d = mem_rdata_i;
        end
        state_d = RSP;
      end
      WR: begin
        if (mem_error_i || mem_done_i || cnt_q == CNT_LAST) begin
          mem_write_d = WR_NONE;
          err_d       = mem_error_i || !mem_done_i;
          state_d     = RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0_o       = 1'b0;
    gnt1_o       = 1'b0;
    rsp_valid0_o = 1'b0;
    rsp_valid1_o = 1'b0;
    rsp_err_o    = 1'b0;
    if (state_q == IDLE) begin
      gnt0_o = grant[0];
      gnt1_o = grant[1];
    end
    if (state_q == RSP) begin
      rsp_valid0_o = (winner_q == PORT_FETCH);
      rsp_valid1_o = (winner_q == PORT_DATA);
      rsp_err_o    = err_q;
    end
  end

  assign rsp_rdata_o   = rsp_rdata_q;
  assign mem_address_o = mem_address_q;
  assign mem_write_o   = mem_write_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: byte-memory model, response scoreboard,
// a vector table of single transactions and hand-written multi-cycle corner cases.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int WR_TIMEOUT = 16;

  logic              clk, rst;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [1:0]        wsize0, wsize1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [1:0]        mem_write;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_done, mem_error;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_TIMEOUT(WR_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .req1_i(req1),
    .addr0_i(addr0), .addr1_i(addr1),
    .wsize0_i(wsize0), .wsize1_i(wsize1),
    .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .rsp_valid0_o(rsp_valid0), .rsp_valid1_o(rsp_valid1),
    .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
    .mem_address_o(mem_address), .mem_write_o(mem_write), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_done_i(mem_done), .mem_error_i(mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 256 bytes, big-endian lanes (d0 = [31:24]), synchronous read, done one cycle after a write.
  logic [7:0] mem [0:255];
  logic       mem_load, done_block;
  logic [7:0] ma;
  assign ma = mem_address[7:0];

  function automatic logic misaligned(input logic [31:0] a, input logic [1:0] sz);
    logic oor;
    oor = |a[31:8];
    case (sz)
      WR_BYTE: return oor;
      WR_HALF: return oor | a[0];
      default: return oor | (a[1:0] != 2'b00);
    endcase
  endfunction

  assign mem_error = misaligned(mem_address, mem_write);

  always @(posedge clk) begin
    mem_rdata <= {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem[8'h10] <= 8'hDE; mem[8'h11] <= 8'hAD; mem[8'h12] <= 8'hBE; mem[8'h13] <= 8'hEF;
      mem[8'h24] <= 8'h11; mem[8'h25] <= 8'h22; mem[8'h26] <= 8'h33; mem[8'h27] <= 8'h44;
      mem_done <= 1'b0;
    end else if (mem_write != WR_NONE && !mem_error && !done_block && !mem_done) begin
      mem[ma] <= mem_wdata[31:24];
      if (mem_write != WR_BYTE) mem[ma + 8'd1] <= mem_wdata[23:16];
      if (mem_write == WR_WORD) begin
        mem[ma + 8'd2] <= mem_wdata[15:8];
        mem[ma + 8'd3] <= mem_wdata[7:0];
      end
      mem_done <= 1'b1;
    end else begin
      mem_done <= 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb_q[$];

  always @(negedge clk) begin
    if (rst && (rsp_valid0 || rsp_valid1)) begin
      check("rsp_onehot", {rsp_valid1, rsp_valid0} == 2'b11, 1'b0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid %b%b, expected none", rsp_valid1, rsp_valid0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        check("rsp_port", rsp_valid1, e.port);
        check("rsp_err", rsp_err, e.err);
        check("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  logic model_ptr;

  function automatic logic model_pick(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return model_ptr;
`else
      return PORT_FETCH;
`endif
    end
    return r1 ? PORT_DATA : PORT_FETCH;
  endfunction

  task automatic expect_rsp(input logic port, input logic err, input logic [31:0] rdata);
    rsp_t e;
    e.port = port; e.err = err; e.rdata = rdata;
    sb_q.push_back(e);
    model_ptr = ~port;
  endtask

  task automatic set_req(input logic port, input logic on, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] d);
    if (port) begin
      req1 = on; addr1 = a; wsize1 = sz; wdata1 = d;
    end else begin
      req0 = on; addr0 = a; wsize0 = sz; wdata0 = d;
    end
  endtask

  task automatic drop_req(input logic port);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  // k counts negedges from the first one after the call; returns at the port's rsp_valid.
  task automatic wait_rsp(input logic port, input logic chk_gnt, input int budget, output int k);
    logic self_gnt, other_gnt, self_rsp;
    k = 0;
    forever begin
      @(negedge clk);
      self_gnt  = port ? gnt1 : gnt0;
      other_gnt = port ? gnt0 : gnt1;
      self_rsp  = port ? rsp_valid1 : rsp_valid0;
      check("gnt_self", self_gnt, chk_gnt && k == 0);
      check("gnt_other", other_gnt, 1'b0);
      if (self_rsp) break;
      if (k >= budget) begin
        checks++;
        errors++;
        $display("FAIL rsp_timeout: port %0d got no rsp_valid, required within %0d cycles", port, budget);
        break;
      end
      k++;
    end
  endtask

  task automatic run_txn(input logic port, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rdata,
                         input int exp_lat);
    int k;
    expect_rsp(port, exp_err, exp_rdata);
    @(posedge clk); #1;
    set_req(port, 1'b1, a, sz, d);
    wait_rsp(port, 1'b1, 40, k);
    check("latency", k, exp_lat);
    drop_req(port);
  endtask

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [1:0]  wsize;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic w, l;
    vecs[0] = '{1'b0, 32'h20, WR_NONE, 32'h0,         1'b0, 32'h12345678, 3};
    vecs[1] = '{1'b1, 32'h30, WR_NONE, 32'h0,         1'b0, 32'hCAFEF00D, 3};
    vecs[2] = '{1'b1, 32'h24, WR_BYTE, 32'hAB000000,  1'b0, 32'hCAFEF00D, 3};
    vecs[3] = '{1'b1, 32'h26, WR_HALF, 32'hCDEF0000,  1'b0, 32'hCAFEF00D, 3};
    vecs[4] = '{1'b0, 32'h24, WR_NONE, 32'h0,         1'b0, 32'hAB22CDEF, 3};
    vecs[5] = '{1'b1, 32'h21, WR_HALF, 32'h99990000,  1'b1, 32'hAB22CDEF, 2};
    vecs[6] = '{1'b0, 32'h20, WR_NONE, 32'h0,         1'b0, 32'h12345678, 3};
    vecs[7] = '{1'b1, 32'h12, WR_NONE, 32'h0,         1'b1, 32'h12345678, 2};
    vecs[8] = '{1'b1, 32'h2A, WR_WORD, 32'hFFFFFFFF,  1'b1, 32'h12345678, 2};
    vecs[9] = '{1'b0, 32'h28, WR_NONE, 32'h0,         1'b0, 32'h28292A2B, 3};

    rst = 1'b0; model_ptr = PORT_FETCH; done_block = 1'b0; mem_load = 1'b1;
    req0 = 1'b0; addr0 = '0; wsize0 = WR_NONE; wdata0 = '0;
    req1 = 1'b0; addr1 = '0; wsize1 = WR_NONE; wdata1 = '0;
    repeat (3) @(negedge clk);
    mem_load = 1'b0;
    check("rst_gnt", {gnt1, gnt0}, 2'b00);
    check("rst_rsp_valid", {rsp_valid1, rsp_valid0}, 2'b00);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_write", mem_write, WR_NONE);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b1;

    // Basic read with exact latency.
    run_txn(PORT_FETCH, 32'h10, WR_NONE, 32'h0, 1'b0, 32'hDEADBEEF, 3);

    // Simultaneous requests, two rounds: winner then loser one cycle after winner's rsp.
    for (int r = 0; r < 2; r++) begin
      w = model_pick(1'b1, 1'b1);
      l = ~w;
      expect_rsp(w, 1'b0, 32'hDEADBEEF);
      expect_rsp(l, 1'b0, 32'hDEADBEEF);
      @(posedge clk); #1;
      set_req(PORT_FETCH, 1'b1, 32'h10, WR_NONE, 32'h0);
      set_req(PORT_DATA, 1'b1, 32'h20, WR_WORD, 32'h12345678);
      wait_rsp(w, 1'b1, 40, k);
      check("tie_winner_latency", k, 3);
      drop_req(w);
      wait_rsp(l, 1'b1, 40, k);
      check("tie_loser_latency", k, 3);
      drop_req(l);
    end

    // Word write: mem_write held during WR, cleared once done is seen.
    expect_rsp(PORT_DATA, 1'b0, 32'hDEADBEEF);
    @(posedge clk); #1;
    set_req(PORT_DATA, 1'b1, 32'h30, WR_WORD, 32'hCAFEF00D);
    @(negedge clk);
    check("wr_gnt1", {gnt1, gnt0}, 2'b10);
    @(negedge clk);
    check("wr_mem_write", mem_write, WR_WORD);
    check("wr_mem_address", mem_address, 32'h30);
    check("wr_mem_wdata", mem_wdata, 32'hCAFEF00D);
    @(negedge clk);
    check("wr_mem_write_held", mem_write, WR_WORD);
    wait_rsp(PORT_DATA, 1'b0, 40, k);
    check("wr_rsp_latency", k, 0);
    check("wr_mem_write_cleared", mem_write, WR_NONE);
    drop_req(PORT_DATA);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].port, vecs[i].addr, vecs[i].wsize, vecs[i].wdata,
              vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat);
    end

    // Write timeout, then an immediate grant from IDLE.
    done_block = 1'b1;
    run_txn(PORT_DATA, 32'h40, WR_WORD, 32'h01020304, 1'b1, 32'h28292A2B, WR_TIMEOUT + 1);
    check("timeout_mem_write", mem_write, WR_NONE);
    done_block = 1'b0;
    run_txn(PORT_FETCH, 32'h40, WR_NONE, 32'h0, 1'b0, 32'h40414243, 3);

    // Reset during a write: mem_write drops at once, no response afterwards.
    done_block = 1'b1;
    @(posedge clk); #1;
    set_req(PORT_DATA, 1'b1, 32'h44, WR_WORD, 32'h55AA55AA);
    repeat (3) @(negedge clk);
    check("pre_rst_mem_write", mem_write, WR_WORD);
    rst = 1'b0;
    #1;
    check("rst_mid_mem_write", mem_write, WR_NONE);
    check("rst_mid_rsp", {rsp_valid1, rsp_valid0}, 2'b00);
    model_ptr = PORT_FETCH;
    drop_req(PORT_DATA);
    done_block = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_rsp", {rsp_valid1, rsp_valid0}, 2'b00);
    end
    check("post_rst_rdata", rsp_rdata, 32'h0);
    run_txn(PORT_FETCH, 32'h10, WR_NONE, 32'h0, 1'b0, 32'hDEADBEEF, 3);

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
